// File: rtl/teclado_escaner.sv
// 4x4 keypad scanner: column drive, debounced row sampling, key decode and decimal accumulator.
// Optional auto-repeat while a key is held: define TECLADO_AUTOREPEAT_EN.
`timescale 1ns/1ps
module teclado_escaner #(
  parameter int SCAN_TICKS   = 100_000,
  parameter int DEB_SCANS    = 3,
  parameter int REPEAT_SCANS = 50
) (
  input  logic       Reloj,
  input  logic       Reset_n,
  input  logic [3:0] Filas,
  output logic [3:0] Columnas,
  output logic [3:0] Tecla,
  output logic       Tecla_valida,
  output logic [7:0] N,
  output logic       N_valido,
  output logic       Error
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DW = $clog2(DEB_SCANS + 1);

  if (DEB_SCANS < 1 || REPEAT_SCANS < 1 || SCAN_TICKS < 1) begin : g_bad_param
    $error("teclado_escaner: SCAN_TICKS, DEB_SCANS and REPEAT_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {ESCANEO, REBOTE, PULSADA} estado_t;

  estado_t        state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [3:0]     sync1_q, sync2_q;
  logic [3:0]     col_q, col_d;
  logic [1:0]     row_q, row_d;
  logic [DW-1:0]  deb_q, deb_d;
  logic [DW-1:0]  rel_q, rel_d;
  logic [3:0]     tecla_q, tecla_d;
  logic           tv_q, tv_d;
  logic [7:0]     valor_q, valor_d;
  logic [7:0]     n_q, n_d;
  logic           nv_q, nv_d;
  logic           err_q, err_d;
`ifdef TECLADO_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0]  rep_q, rep_d;
`endif

  logic           tick_end;
  logic           fila_ok;
  logic [1:0]     fila_idx;
  logic [1:0]     col_idx;
  logic [3:0]     col_next;
  logic           same_row;
  logic [11:0]    acc_t;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  assign tick_end = (tick_q == TW'(SCAN_TICKS - 1));
  assign tick_d   = tick_end ? '0 : tick_q + 1'b1;
  assign col_next = {col_q[2:0], col_q[3]};
  assign same_row = (sync2_q == ~(4'b0001 << row_q));

  // Exactly one row low is a key; none or several (ghosting) is treated as nothing pressed.
  always_comb begin
    fila_ok  = 1'b0;
    fila_idx = 2'd0;
    case (sync2_q)
      4'b1110: begin fila_ok = 1'b1; fila_idx = 2'd0; end
      4'b1101: begin fila_ok = 1'b1; fila_idx = 2'd1; end
      4'b1011: begin fila_ok = 1'b1; fila_idx = 2'd2; end
      4'b0111: begin fila_ok = 1'b1; fila_idx = 2'd3; end
      default: begin fila_ok = 1'b0; fila_idx = 2'd0; end
    endcase
  end

  always_comb begin
    col_idx = 2'd0;
    case (col_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    deb_d   = deb_q;
    rel_d   = rel_q;
    tecla_d = tecla_q;
    tv_d    = 1'b0;
`ifdef TECLADO_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick_end) begin
      case (state_q)
        ESCANEO: begin
          if (fila_ok) begin
            row_d = fila_idx;
            if (DEB_SCANS == 1) begin
              tecla_d = key_code(fila_idx, col_idx);
              tv_d    = 1'b1;
              rel_d   = '0;
`ifdef TECLADO_AUTOREPEAT_EN
              rep_d   = '0;
`endif
              state_d = PULSADA;
            end else begin
              deb_d   = DW'(1);
              state_d = REBOTE;
            end
          end else begin
            col_d = col_next;
          end
        end
        REBOTE: begin
          if (same_row) begin
            if (deb_q + 1'b1 == DW'(DEB_SCANS)) begin
              tecla_d = key_code(row_q, col_idx);
              tv_d    = 1'b1;
              rel_d   = '0;
`ifdef TECLADO_AUTOREPEAT_EN
              rep_d   = '0;
`endif
              state_d = PULSADA;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            col_d   = col_next;
            state_d = ESCANEO;
          end
        end
        PULSADA: begin
          // Only the captured row matters here; other keys on this column are ignored.
          if (sync2_q[row_q]) begin
`ifdef TECLADO_AUTOREPEAT_EN
            rep_d = '0;
`endif
            if (rel_q + 1'b1 == DW'(DEB_SCANS)) begin
              rel_d   = '0;
              col_d   = col_next;
              state_d = ESCANEO;
            end else begin
              rel_d = rel_q + 1'b1;
            end
          end else begin
            rel_d = '0;
`ifdef TECLADO_AUTOREPEAT_EN
            if (rep_q + 1'b1 == RW'(REPEAT_SCANS)) begin
              rep_d = '0;
              tv_d  = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
            end
`endif
          end
        end
        default: begin
          state_d = ESCANEO;
          col_d   = 4'b1110;
        end
      endcase
    end
  end

  // 12-bit product so 255*10+9 cannot wrap before the overflow test.
  assign acc_t = ({4'd0, valor_q} * 12'd10) + {8'd0, tecla_q};

  always_comb begin
    valor_d = valor_q;
    n_d     = n_q;
    nv_d    = 1'b0;
    err_d   = 1'b0;
    if (tv_q) begin
      if (tecla_q <= 4'd9) begin
        if (acc_t <= 12'd255) valor_d = acc_t[7:0];
        else                  err_d   = 1'b1;
      end else if (tecla_q == 4'hE) begin
        valor_d = 8'd0;
      end else if (tecla_q == 4'hF) begin
        n_d     = valor_q;
        nv_d    = 1'b1;
        valor_d = 8'd0;
      end
    end
  end

  always_ff @(posedge Reloj) begin
    if (!Reset_n) begin
      state_q <= ESCANEO;
      tick_q  <= '0;
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
      col_q   <= 4'b1110;
      row_q   <= 2'd0;
      deb_q   <= '0;
      rel_q   <= '0;
      tecla_q <= 4'd0;
      tv_q    <= 1'b0;
      valor_q <= 8'd0;
      n_q     <= 8'd0;
      nv_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef TECLADO_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      sync1_q <= Filas;
      sync2_q <= sync1_q;
      col_q   <= col_d;
      row_q   <= row_d;
      deb_q   <= deb_d;
      rel_q   <= rel_d;
      tecla_q <= tecla_d;
      tv_q    <= tv_d;
      valor_q <= valor_d;
      n_q     <= n_d;
      nv_q    <= nv_d;
      err_q   <= err_d;
`ifdef TECLADO_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign Columnas     = col_q;
  assign Tecla        = tecla_q;
  assign Tecla_valida = tv_q;
  assign N            = n_q;
  assign N_valido     = nv_q;
  assign Error        = err_q;

endmodule
